// File: rtl/chkmon_pkg.sv
// chkmon_pkg: shared state type and constants for checkpoint_seq_monitor
// and its stability counter.
package chkmon_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int                  ELAPSED_W    = 32;
   localparam logic [ELAPSED_W-1:0] ELAPSED_MAX = '1;
   localparam int                  STABLE_CNT_W = 8;

endpackage

// File: rtl/chkmon_stable_cnt.sv
// chkmon_stable_cnt: counts consecutive matching cycles and flags the cycle on
// which the hold reaches STABLE_CYCLES; the count then restarts from zero.
module chkmon_stable_cnt
   import chkmon_pkg::*;
#(
   parameter int STABLE_CYCLES = 1
)(
   input  logic clk,
   input  logic srst,
   input  logic clear,
   input  logic match,
   output logic hit
);

   logic [STABLE_CNT_W-1:0] cnt_reg;

   // An unknown match evaluates false in both branches below.
   always_comb begin
      hit = 1'b0;
      if (!clear && match && (cnt_reg == STABLE_CNT_W'(STABLE_CYCLES - 1)))
         hit = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (srst || clear) begin
         cnt_reg <= '0;
      end else if (match) begin
         if (hit)
            cnt_reg <= '0;
         else
            cnt_reg <= cnt_reg + STABLE_CNT_W'(1);
      end else begin
         cnt_reg <= '0;
      end
   end

endmodule

// File: rtl/checkpoint_seq_monitor.sv
// checkpoint_seq_monitor: watches check_bits for an ordered sequence of held
// signatures within a cycle budget. Define CHKMON_ORDER_ERR_EN for out-of-order detection.
module checkpoint_seq_monitor
   import chkmon_pkg::*;
#(
   parameter int WIDTH          = 16,
   parameter int DEPTH          = 2,
   parameter int TIMEOUT_CYCLES = 70000,
   parameter int STABLE_CYCLES  = 1
)(
   input  logic                         wb_clk_i,
   input  logic                         wb_rst_i,
   input  logic                         arm,
   input  logic [WIDTH-1:0]             check_bits,
   input  logic                         sig_we,
   input  logic [$clog2(DEPTH)-1:0]     sig_idx,
   input  logic [WIDTH-1:0]             sig_data,
   output logic                         busy,
   output logic                         started,
   output logic                         passed,
   output logic                         timed_out,
   output logic                         order_err,
   output logic [$clog2(DEPTH+1)-1:0]   stage,
   output logic [31:0]                  elapsed
);

   localparam int IDX_W   = $clog2(DEPTH);
   localparam int STAGE_W = $clog2(DEPTH + 1);
   localparam int TABLE_N = 1 << IDX_W;

   state_t               state_reg;
   logic                 busy_reg, started_reg, passed_reg, timed_out_reg;
   logic [STAGE_W-1:0]   stage_reg;
   logic [ELAPSED_W-1:0] elapsed_reg, elapsed_next;
   logic [WIDTH-1:0]     sig_reg [TABLE_N];
   logic [WIDTH-1:0]     cur_sig;
   logic                 stage_match, stage_hit, cnt_clear, last_stage, timeout_hit;

   // Entries at or beyond DEPTH are never written and stay zero.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         for (int i = 0; i < TABLE_N; i++)
            sig_reg[i] <= '0;
      end else if (sig_we && (int'(sig_idx) < DEPTH)) begin
         sig_reg[sig_idx] <= sig_data;
      end
   end

   assign cur_sig      = sig_reg[stage_reg[IDX_W-1:0]];
   assign stage_match  = (check_bits == cur_sig);
   assign cnt_clear    = arm || (state_reg != RUN);
   assign last_stage   = (stage_reg == STAGE_W'(DEPTH - 1));
   assign elapsed_next = (elapsed_reg == ELAPSED_MAX) ? elapsed_reg : elapsed_reg + ELAPSED_W'(1);
   assign timeout_hit  = (elapsed_next >= ELAPSED_W'(TIMEOUT_CYCLES - 1));

   chkmon_stable_cnt #(.STABLE_CYCLES(STABLE_CYCLES)) u_stage_cnt (
      .clk   (wb_clk_i),
      .srst  (wb_rst_i),
      .clear (cnt_clear),
      .match (stage_match),
      .hit   (stage_hit)
   );

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_reg     <= IDLE;
         busy_reg      <= 1'b0;
         started_reg   <= 1'b0;
         passed_reg    <= 1'b0;
         timed_out_reg <= 1'b0;
         stage_reg     <= '0;
         elapsed_reg   <= '0;
      end else if (arm) begin
         state_reg     <= RUN;
         busy_reg      <= 1'b1;
         started_reg   <= 1'b0;
         passed_reg    <= 1'b0;
         timed_out_reg <= 1'b0;
         stage_reg     <= '0;
         elapsed_reg   <= '0;
      end else if (state_reg == RUN) begin
         elapsed_reg <= elapsed_next;
         if (stage_hit) begin
            stage_reg   <= stage_reg + STAGE_W'(1);
            started_reg <= 1'b1;
         end
         // A final match on the expiry edge counts as a pass.
         if (stage_hit && last_stage) begin
            passed_reg <= 1'b1;
            state_reg  <= DONE;
            busy_reg   <= 1'b0;
         end else if (timeout_hit) begin
            timed_out_reg <= 1'b1;
            state_reg     <= DONE;
            busy_reg      <= 1'b0;
         end
      end
   end

   assign busy      = busy_reg;
   assign started   = started_reg;
   assign passed    = passed_reg;
   assign timed_out = timed_out_reg;
   assign stage     = stage_reg;
   assign elapsed   = elapsed_reg;

`ifdef CHKMON_ORDER_ERR_EN
   logic [DEPTH-1:0] later_match;
   logic             order_match, order_hit, order_err_reg;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_later
      assign later_match[gi] = (STAGE_W'(gi) > stage_reg) && (check_bits == sig_reg[gi]);
   end

   // A value that also equals the current signature is the expected one.
   assign order_match = |later_match && !stage_match;

   chkmon_stable_cnt #(.STABLE_CYCLES(STABLE_CYCLES)) u_order_cnt (
      .clk   (wb_clk_i),
      .srst  (wb_rst_i),
      .clear (cnt_clear || stage_hit),
      .match (order_match),
      .hit   (order_hit)
   );

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || arm)
         order_err_reg <= 1'b0;
      else if ((state_reg == RUN) && order_hit)
         order_err_reg <= 1'b1;
   end

   assign order_err = order_err_reg;
`else
   assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// tb_checkpoint_seq_monitor: scoreboard bench; a cycle-level reference model
// queues expected outputs and a monitor compares them after every clock edge.
module tb_checkpoint_seq_monitor;

   localparam int W  = 16;
   localparam int D  = 3;
   localparam int T  = 120;
   localparam int S  = 2;
   localparam int IW = $clog2(D);
   localparam int SW = $clog2(D + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b0, arm = 1'b0, we = 1'b0;
   logic [W-1:0]  cb = '0, data = '0;
   logic [IW-1:0] idx = '0;
   logic          busy, started, passed, timed_out, order_err;
   logic [SW-1:0] stage;
   logic [31:0]   elapsed;

   always #5 clk = ~clk;

   checkpoint_seq_monitor #(
      .WIDTH(W), .DEPTH(D), .TIMEOUT_CYCLES(T), .STABLE_CYCLES(S)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .arm(arm), .check_bits(cb),
      .sig_we(we), .sig_idx(idx), .sig_data(data),
      .busy(busy), .started(started), .passed(passed), .timed_out(timed_out),
      .order_err(order_err), .stage(stage), .elapsed(elapsed)
   );

   typedef struct packed {
      logic          busy;
      logic          started;
      logic          passed;
      logic          timed_out;
      logic          order_err;
      logic [SW-1:0] stage;
      logic [31:0]   elapsed;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0, errors = 0, txn = 0;

   // Reference model: sequence progress expressed with plain integers.
   logic [W-1:0] m_sig [D];
   bit           m_run, m_passed, m_to;
   int           m_stage, m_hold;
   longint       m_elapsed;

   task automatic model_step();
      bit was_run = m_run;
      if (rst) begin
         m_run = 0; m_passed = 0; m_to = 0; m_stage = 0; m_hold = 0; m_elapsed = 0;
         for (int i = 0; i < D; i++) m_sig[i] = '0;
      end else begin
         if (arm) begin
            m_run = 1; m_passed = 0; m_to = 0; m_stage = 0; m_hold = 0; m_elapsed = 0;
         end else if (m_run) begin
            if (m_elapsed < 64'hFFFF_FFFF) m_elapsed++;
            if (cb == m_sig[m_stage]) begin
               m_hold++;
               if (m_hold == S) begin m_hold = 0; m_stage++; end
            end else begin
               m_hold = 0;
            end
            if (m_stage == D) begin
               m_passed = 1; m_run = 0;
            end else if (m_elapsed >= T - 1) begin
               m_to = 1; m_run = 0;
            end
         end
         if (we && int'(idx) < D) m_sig[idx] = data;
      end
      if (was_run && !m_run && !rst) begin
         txn++;
         $display("txn %0d end: passed=%0d timed_out=%0d stage=%0d elapsed=%0d",
                  txn, m_passed, m_to, m_stage, m_elapsed);
      end
      exp_q.push_back('{busy: m_run, started: (m_stage > 0), passed: m_passed,
                        timed_out: m_to, order_err: 1'b0, stage: SW'(m_stage),
                        elapsed: 32'(m_elapsed)});
   endtask

   task automatic drive(input bit r, input bit a, input logic [W-1:0] c,
                        input bit w, input logic [IW-1:0] i, input logic [W-1:0] d);
      @(negedge clk);
      rst = r; arm = a; cb = c; we = w; idx = i; data = d;
      model_step();
   endtask

   task automatic drive_val(input logic [W-1:0] c);
      drive(0, 0, c, 0, '0, '0);
   endtask

   task automatic settle();
      @(posedge clk); #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] noise();
      logic [W-1:0] v;
      bit hit;
      do begin
         v = W'($urandom);
         hit = 0;
         for (int i = 0; i < D; i++) if (v == m_sig[i]) hit = 1;
      end while (hit);
      return v;
   endfunction

   function automatic logic [W-1:0] pool();
      logic [W-1:0] vals [5] = '{16'hAB60, 16'hAB61, 16'hAB62, 16'hAB63, 16'h0000};
      return vals[$urandom_range(0, 4)];
   endfunction

   task automatic load_table();
      drive(0, 0, '0, 1, 2'd0, 16'hAB60);
      drive(0, 0, '0, 1, 2'd1, 16'hAB61);
      drive(0, 0, '0, 1, 2'd2, 16'hAB62);
      drive(0, 0, '0, 1, 2'd3, 16'hFFFF);
   endtask

   task automatic random_phase();
      for (int n = 0; n < 3000; n++) begin
         bit           r   = ($urandom_range(0, 299) == 0);
         bit           a   = ($urandom_range(0, 79) == 0) || (!m_run && $urandom_range(0, 5) == 0);
         bit           w   = ($urandom_range(0, 9) == 0);
         logic [IW-1:0] i  = IW'($urandom);
         logic [W-1:0] d   = pool();
         int           sel = $urandom_range(0, 99);
         logic [W-1:0] c;
         if (sel < 70)      c = m_run ? m_sig[m_stage] : pool();
         else if (sel < 85) c = m_sig[$urandom_range(0, D - 1)];
         else               c = W'($urandom);
         drive(r, a, c, w, i, d);
      end
   endtask

   initial begin : monitor
      obs_t e, a;
      forever begin
         @(posedge clk); #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{busy: busy, started: started, passed: passed, timed_out: timed_out,
                  order_err: order_err, stage: stage, elapsed: elapsed};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL cycle_state t=%0t got b%0d s%0d p%0d t%0d o%0d stg%0d el%0d expected b%0d s%0d p%0d t%0d o%0d stg%0d el%0d",
                        $time, a.busy, a.started, a.passed, a.timed_out, a.order_err, a.stage, a.elapsed,
                        e.busy, e.started, e.passed, e.timed_out, e.order_err, e.stage, e.elapsed);
            end
         end
      end
   end

   initial begin
      drive(1, 0, '0, 0, '0, '0);
      drive(1, 0, '0, 0, '0, '0);
      settle();
      check("rst_busy", 64'(busy), 0);
      check("rst_stage", 64'(stage), 0);
      check("rst_elapsed", 64'(elapsed), 0);
      check("rst_flags", 64'({started, passed, timed_out, order_err}), 0);

      // Ordered sequence with fixed match times.
      load_table();
      drive(0, 1, noise(), 0, '0, '0);
      repeat (10) drive_val(noise());
      drive_val(16'hAB60); settle();
      check("seq_started_early", 64'(started), 0);
      drive_val(16'hAB60); settle();
      check("seq_started", 64'(started), 1);
      check("seq_stage1", 64'(stage), 1);
      check("seq_elapsed12", 64'(elapsed), 12);
      repeat (8) drive_val(noise());
      repeat (2) drive_val(16'hAB61);
      repeat (8) drive_val(noise());
      repeat (2) drive_val(16'hAB62);
      settle();
      check("seq_passed", 64'(passed), 1);
      check("seq_busy_low", 64'(busy), 0);
      check("seq_elapsed", 64'(elapsed), 32);
      check("seq_stage_full", 64'(stage), D);
      repeat (5) drive_val(noise());
      settle();
      check("seq_elapsed_frozen", 64'(elapsed), 32);

      // Budget expiry with no match.
      drive(0, 1, noise(), 0, '0, '0);
      repeat (T - 2) drive_val(noise());
      settle();
      check("to_busy_before", 64'(busy), 1);
      drive_val(noise()); settle();
      check("to_flag", 64'(timed_out), 1);
      check("to_busy", 64'(busy), 0);
      check("to_passed", 64'(passed), 0);
      check("to_elapsed", 64'(elapsed), T - 1);

      // Broken hold must restart.
      drive(0, 1, noise(), 0, '0, '0);
      drive_val(16'hAB60); settle();
      check("hold_partial", 64'(stage), 0);
      drive_val(16'h0000);
      drive_val(16'hAB60); settle();
      check("hold_restart", 64'(stage), 0);
      drive_val(16'hAB60); settle();
      check("hold_full", 64'(stage), 1);

      // Reset mid-run beats arm and sig_we; the table is cleared.
      drive(1, 1, '0, 1, 2'd0, 16'hFFFF); settle();
      check("mid_rst_outputs", 64'({busy, started, passed, timed_out, order_err}), 0);
      check("mid_rst_stage", 64'(stage), 0);
      check("mid_rst_elapsed", 64'(elapsed), 0);
      drive(0, 1, '0, 0, '0, '0);
      repeat (D * S) drive_val(16'h0000);
      settle();
      check("zero_table_pass", 64'(passed), 1);
      check("zero_table_elapsed", 64'(elapsed), D * S);

      // Final match on the expiry edge.
      load_table();
      drive(0, 1, noise(), 0, '0, '0);
      repeat (T - 1 - D * S) drive_val(noise());
      repeat (S) drive_val(16'hAB60);
      repeat (S) drive_val(16'hAB61);
      repeat (S) drive_val(16'hAB62);
      settle();
      check("tie_passed", 64'(passed), 1);
      check("tie_timed_out", 64'(timed_out), 0);
      check("tie_elapsed", 64'(elapsed), T - 1);

      random_phase();

      repeat (3) drive_val('0);
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
      #2;
      check("scoreboard_drained", 64'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
